// File: rtl/instr_fetch_if.sv
// instr_fetch_if: memory read port and decoder handshake of the fetch stage
interface instr_fetch_if;
    logic [14:0] o_addr;
    logic        o_read;
    logic [47:0] i_data;
    logic        i_done;
    logic [23:0] o_cmd;
    logic        o_valid;
    logic        i_ready;
    logic [14:0] o_pc;
    logic        o_right;
    logic        i_jump;
    logic [14:0] i_jump_addr;

    modport master (
        output o_addr, o_read, o_cmd, o_valid, o_pc, o_right,
        input  i_data, i_done, i_ready, i_jump, i_jump_addr
    );

    modport slave (
        input  o_addr, o_read, o_cmd, o_valid, o_pc, o_right,
        output i_data, i_done, i_ready, i_jump, i_jump_addr
    );
endinterface

// File: rtl/instr_fetch.sv
// instr_fetch: fetches 48-bit words and hands them to the decoder as two 24-bit commands
module instr_fetch #(
    parameter logic [14:0] RESET_PC = 15'o00001
) (
    input logic           clk,
    input logic           reset,
    instr_fetch_if.master bus
);
    typedef enum logic [2:0] {START, REQ, WAIT, LEFT, RIGHT, DROP} state_t;

    state_t      state, next;
    logic [14:0] pc, cmd_pc;
    logic [23:0] word_right, cmd;
    logic        jump, latch;

    assign jump        = bus.i_jump && state != START;
    assign latch       = state == WAIT && bus.i_done && !bus.i_jump;
    assign bus.o_read  = state == REQ;
    assign bus.o_addr  = state == REQ ? pc : '0;
    assign bus.o_valid = state == LEFT || state == RIGHT;
    assign bus.o_right = state == RIGHT;
    assign bus.o_cmd   = cmd;
    assign bus.o_pc    = cmd_pc;

    // next state: a jump beats i_ready; a read still in flight at a jump is drained in DROP
    always_comb begin
        next = state;
        case (state)
            START:   next = REQ;
            REQ:     next = jump ? DROP : WAIT;
            WAIT:    next = bus.i_done ? (jump ? REQ : LEFT) : (jump ? DROP : WAIT);
            LEFT:    next = jump ? REQ : (bus.i_ready ? RIGHT : LEFT);
            RIGHT:   next = (jump || bus.i_ready) ? REQ : RIGHT;
            DROP:    next = bus.i_done ? REQ : DROP;
            default: next = START;
        endcase
    end

    // state, program counter, buffered right half and the command/pc presented downstream
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= START;
            pc         <= RESET_PC;
            word_right <= '0;
            cmd        <= '0;
            cmd_pc     <= RESET_PC;
        end else begin
            state <= next;
            if (jump)
                pc <= bus.i_jump_addr;
            else if (state == RIGHT && bus.i_ready)
                pc <= pc + 15'd1;
            if (latch) begin
                word_right <= bus.i_data[23:0];
                cmd        <= bus.i_data[47:24];
                cmd_pc     <= pc;
            end else if (state == LEFT && bus.i_ready && !bus.i_jump) begin
                cmd <= word_right;
            end
        end
    end
endmodule
